tanh_lut_loader: RTL and testbench

TANH_LUT_LOADER -- requirements
Module: tanh_lut_loader

---
 rtl/tanh_pkg.sv | 26 ++
 rtl/lut_checksum.sv | 27 ++
 rtl/tanh_lut_loader.sv | 158 +++++++++++++++
 tb/tb_tanh_lut_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tanh_pkg.sv
// Shared types and constants for the tanh lookup-table loader: FSM states,
// error causes and the fixed-point ONE used by the range check.
package tanh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_MONO  = 2'd2;
    localparam logic [1:0] ERR_CSUM  = 2'd3;

    // 1.0 in a fixed-point format with q fractional bits.
    function automatic logic [63:0] one_of(input int unsigned q);
        return 64'd1 << q;
    endfunction

    localparam int unsigned DEFAULT_Q = 16;
    localparam logic [63:0] ONE       = one_of(DEFAULT_Q);

endpackage

// File: rtl/lut_checksum.sv
// Running DW-bit sum modulo 2^DW with synchronous clear; sum_next exposes
// the value the register will take if the current word is accumulated.
module lut_checksum #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          acc,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] sum,
    output logic [DW-1:0] sum_next
);

    assign sum_next = sum + data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (acc) begin
            sum <= sum_next;
        end
    end

endmodule

// File: rtl/tanh_lut_loader.sv
// Streams a tanh table into an external dual-port RAM with range and
// monotonic checks, then reads it back and compares write/read checksums.
module tanh_lut_loader
    import tanh_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32,
    parameter int Q  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err_code,
    output state_t        dbg_state
);

    // Handshake: a word moves when s_valid && s_ready at a rising edge;
    // s_ready is high exactly while in LOAD, and a rejected word is consumed
    // (the loader leaves LOAD) but never written.

    localparam logic [DW-1:0] ONE_W     = DW'(one_of(Q));
    localparam logic [AW-1:0] ADDR_LAST = '1;
    localparam logic [AW:0]   VCNT_LAST = {1'b1, {AW{1'b0}}};

    state_t        state, state_nxt;
    logic [1:0]    err_q, err_nxt;
    logic [AW-1:0] addr_cnt;
    logic [AW:0]   vcnt;
    logic [DW-1:0] prev_word;

    logic          xfer;
    logic          range_bad;
    logic          mono_bad;
    logic          wr_fire;
    logic          start_ok;
    logic          rd_vld;
    logic [DW-1:0] wr_sum, wr_sum_next;
    logic [DW-1:0] rd_sum, rd_sum_next;

    assign xfer      = (state == ST_LOAD) && s_valid;
    assign range_bad = s_data[DW-1] || (s_data > ONE_W);
    assign mono_bad  = (addr_cnt != '0) && (s_data < prev_word);
    assign wr_fire   = xfer && !range_bad && !mono_bad;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    // Read data lags the address by one cycle, so sweep cycle k sums address k-1.
    assign rd_vld    = (state == ST_VERIFY) && (vcnt != '0);

    lut_checksum #(.DW(DW)) u_wr_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .acc      (wr_fire),
        .data     (s_data),
        .sum      (wr_sum),
        .sum_next (wr_sum_next)
    );

    lut_checksum #(.DW(DW)) u_rd_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .acc      (rd_vld),
        .data     (rd_data),
        .sum      (rd_sum),
        .sum_next (rd_sum_next)
    );

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_ok) begin
                    state_nxt = ST_LOAD;
                    err_nxt   = ERR_NONE;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    if (range_bad) begin
                        state_nxt = ST_ERR;
                        err_nxt   = ERR_RANGE;
                    end else if (mono_bad) begin
                        state_nxt = ST_ERR;
                        err_nxt   = ERR_MONO;
                    end else if (addr_cnt == ADDR_LAST) begin
                        state_nxt = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                // The last read word is still in flight, so compare with sum_next.
                if (vcnt == VCNT_LAST) begin
                    if (rd_sum_next == wr_sum) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_ERR;
                        err_nxt   = ERR_CSUM;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                err_nxt   = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            err_q     <= ERR_NONE;
            addr_cnt  <= '0;
            vcnt      <= '0;
            prev_word <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            if (start_ok) begin
                addr_cnt  <= '0;
                prev_word <= '0;
            end else if (wr_fire) begin
                addr_cnt  <= addr_cnt + AW'(1);
                prev_word <= s_data;
            end
            if (state == ST_VERIFY) begin
                vcnt <= vcnt + (AW+1)'(1);
            end else begin
                vcnt <= '0;
            end
        end
    end

    // wr_sum_next is only consumed through the write path; keep it observable.
    logic unused_wr_next;
    assign unused_wr_next = ^wr_sum_next;

    assign s_ready   = (state == ST_LOAD);
    assign wr_en     = wr_fire;
    assign wr_addr   = addr_cnt;
    assign wr_data   = wr_fire ? s_data : '0;
    assign rd_addr   = ((state == ST_VERIFY) && (vcnt != VCNT_LAST)) ? vcnt[AW-1:0] : '0;
    assign busy      = (state == ST_LOAD) || (state == ST_VERIFY);
    assign done      = (state == ST_DONE);
    assign err_code  = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_tanh_lut_loader.sv
// Bench for tanh_lut_loader (AW=4): directed loads through a RAM model, with an
// expected-write queue checked by an independent write monitor.
module tb_tanh_lut_loader;
    import tanh_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;
    state_t        dbg_state;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            t0 = 0;
    int            wr_cnt = 0;
    bit            corrupt = 1'b0;
    bit            wrote [N];
    logic [DW-1:0] tbl [N];
    logic [DW-1:0] mem [N];
    logic [AW+DW-1:0] exp_q [$];

    tanh_lut_loader #(.AW(AW), .DW(DW), .Q(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code),
        .dbg_state (dbg_state)
    );

    // clock / reset-free cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dual-port RAM model with registered read address; address 9 can be corrupted
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr] ^ ((corrupt && rd_addr == 4'd9) ? 32'h1 : 32'h0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every RAM write must match the head of the expected queue
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            wrote[wr_addr] = 1'b1;
            check("wr_in_load", 64'(dbg_state), 64'(ST_LOAD));
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'({wr_addr, wr_data}), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("write", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic init_tbl();
        for (int i = 0; i < N - 1; i++) tbl[i] = 32'(i) * 32'h1000;
        tbl[N-1] = 32'h0001_0000;
        for (int i = 0; i < N; i++) wrote[i] = 1'b0;
    endtask

    task automatic expect_writes(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back({AW'(i), tbl[i]});
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic send_words(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bit taken = 1'b0;
            int guard = 0;
            while (!taken) begin
                s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                s_data  = tbl[i];
                @(negedge clk);
                taken = s_valid && s_ready;
                @(posedge clk);
                #1;
                guard++;
                if (!taken && guard > 50) begin
                    check("send_timeout", 64'(i), 64'hFFFF);
                    s_valid = 1'b0;
                    return;
                end
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_end(output int lat);
        lat = -1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (done || err_code != ERR_NONE) begin
                lat = cyc - t0;
                return;
            end
        end
        check("end_timeout", 64'(busy), 64'(0));
    endtask

    initial begin
        int lat;
        int w0;

        // reset values, applied asynchronously at time 0
        #3;
        check("reset_outputs", 64'({s_ready, wr_en, wr_addr, wr_data, rd_addr, busy, done, err_code}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h100;
        repeat (3) @(posedge clk);
        #1;
        check("idle_until_start", 64'(dbg_state), 64'(ST_IDLE));
        check("no_write_when_idle", 64'(wr_cnt), 64'(0));
        s_valid = 1'b0;

        // gapless full load, with a start pulse ignored during VERIFY
        init_tbl();
        expect_writes(0, N - 1);
        pulse_start();
        send_words(N, 1'b0);
        check("busy_in_verify", 64'({busy, dbg_state}), 64'({1'b1, ST_VERIFY}));
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_end(lat);
        check("gapless_latency", 64'(lat), 64'(33));
        check("gapless_result", 64'({done, err_code, busy}), 64'({1'b1, ERR_NONE, 1'b0}));
        check("gapless_queue", 64'(exp_q.size()), 64'(0));

        // same table with random valid gaps
        init_tbl();
        expect_writes(0, N - 1);
        pulse_start();
        send_words(N, 1'b1);
        wait_end(lat);
        check("gaps_result", 64'({done, err_code}), 64'({1'b1, ERR_NONE}));
        check("gaps_queue", 64'(exp_q.size()), 64'(0));

        // word 5 above ONE: range error after 5 writes
        init_tbl();
        tbl[5] = 32'h0001_0001;
        expect_writes(0, 4);
        w0 = wr_cnt;
        pulse_start();
        send_words(6, 1'b0);
        check("range_err", 64'({err_code, done, busy}), 64'({ERR_RANGE, 1'b0, 1'b0}));
        check("range_writes", 64'(wr_cnt - w0), 64'(5));
        check("range_ready_low", 64'(s_ready), 64'(0));

        // sign bit set on the very first word
        init_tbl();
        tbl[0] = 32'h8000_0000;
        w0 = wr_cnt;
        pulse_start();
        send_words(1, 1'b0);
        check("sign_err", 64'(err_code), 64'(ERR_RANGE));
        check("sign_writes", 64'(wr_cnt - w0), 64'(0));

        // word 7 below word 6: monotonic error, address 7 untouched
        init_tbl();
        tbl[7] = 32'h0000_5FFF;
        expect_writes(0, 6);
        pulse_start();
        send_words(8, 1'b1);
        check("mono_err", 64'(err_code), 64'(ERR_MONO));
        check("mono_addr7", 64'(wrote[7]), 64'(0));
        check("mono_queue", 64'(exp_q.size()), 64'(0));

        // RAM corrupts address 9 on readback: checksum error after the full sweep
        init_tbl();
        corrupt = 1'b1;
        expect_writes(0, N - 1);
        pulse_start();
        send_words(N, 1'b0);
        wait_end(lat);
        check("csum_latency", 64'(lat), 64'(33));
        check("csum_err", 64'({err_code, done}), 64'({ERR_CSUM, 1'b0}));
        corrupt = 1'b0;

        // reset in the middle of LOAD at address 8, then a clean reload
        init_tbl();
        expect_writes(0, 7);
        pulse_start();
        send_words(8, 1'b0);
        #1 rst = 1'b1;
        s_valid = 1'b1;
        s_data  = tbl[8];
        #1;
        check("midload_reset", 64'({s_ready, wr_en, wr_addr, wr_data, rd_addr, busy, done, err_code}), 64'(0));
        check("midload_state", 64'(dbg_state), 64'(ST_IDLE));
        s_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midload_queue", 64'(exp_q.size()), 64'(0));
        init_tbl();
        expect_writes(0, N - 1);
        pulse_start();
        send_words(N, 1'b0);
        wait_end(lat);
        check("reload_result", 64'({done, err_code}), 64'({1'b1, ERR_NONE}));
        check("reload_latency", 64'(lat), 64'(33));
        check("reload_queue", 64'(exp_q.size()), 64'(0));

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
